manchester_frame_tx: RTL and testbench

Parametrised Manchester-encoded frame transmitter feeding the single-wire link that the PLL-based receiver recovers. It accepts one payload word per valid/ready handshake and serialises preamble, sync field and payload, MSB first, at a programmable half-bit rate. A minimum inter-frame gap is enforced after each frame. It supersedes the fixed 64-bit test-pattern generator with configurable lengths, flow control, clean abort and frame-done signalling.

---
 rtl/manchester_pkg.sv | 27 ++
 rtl/manchester_frame_tx_baud_gen.sv | 33 +++
 rtl/manchester_frame_tx.sv | 180 ++++++++++++++++++
 tb/tb_manchester_frame_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester frame transmitter and its receiver.
//   state_t              : frame sequencer states
//   SYNC_PATTERN_DEFAULT : default sync field value, also used by the receiver
//   encode()             : IEEE 802.3 Manchester half-bit level for (bit, phase)
//   max_int()            : elaboration-time helper for counter sizing
package manchester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        DATA,
        GAP
    } state_t;

    localparam logic [1:0] SYNC_PATTERN_DEFAULT = 2'b10;

    // A 1 is sent low-then-high, a 0 is sent high-then-low.
    function automatic logic encode(input logic bit_val, input logic phase);
        return phase ? bit_val : ~bit_val;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/manchester_frame_tx_baud_gen.sv
// Half-bit rate divider.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous restart of the divider
//   o_tick  : one-cycle pulse on the last clock of every half-bit
module manchester_baud_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == DIV_W'(CLK_DIV - 1));
    assign o_tick = w_last && !i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/manchester_frame_tx.sv
// Manchester frame transmitter: preamble, sync field and payload, MSB first.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_enable : low aborts any frame and holds the block idle
//   i_data   : payload, latched on acceptance
//   i_valid  : payload valid
//   o_ready  : block can accept a payload
//   o_tx     : registered Manchester line output
//   o_busy   : high while a frame or its trailing gap is in progress
//   o_done   : one-cycle pulse after the last data half-bit
//
// state    | meaning
// IDLE     | line at IDLE_LEVEL, ready for a payload
// PREAMBLE | sending PREAMBLE_BITS logical ones
// SYNC     | sending the sync pattern
// DATA     | sending the latched payload
// GAP      | forced idle line after a frame, not ready
module manchester_frame_tx
    import manchester_pkg::*;
#(
    parameter int                   DATA_W        = 64,
    parameter int                   PREAMBLE_BITS = 64,
    parameter int                   SYNC_BITS     = 2,
    parameter logic [SYNC_BITS-1:0] SYNC_PATTERN  = SYNC_BITS'(SYNC_PATTERN_DEFAULT),
    parameter int                   CLK_DIV       = 1,
    parameter int                   GAP_HALFBITS  = 4,
    parameter logic                 IDLE_LEVEL    = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int PRE_HB   = 2 * PREAMBLE_BITS;
    localparam int SYNC_HB  = 2 * SYNC_BITS;
    localparam int DATA_HB  = 2 * DATA_W;
    localparam int HB_MAX   = max_int(max_int(PRE_HB, SYNC_HB), max_int(DATA_HB, GAP_HALFBITS));
    localparam int HB_W     = $clog2(HB_MAX);
    localparam int GAP_LAST = (GAP_HALFBITS > 0) ? GAP_HALFBITS - 1 : 0;

    state_t                r_state;
    logic [HB_W-1:0]       r_hb_cnt;
    logic [DATA_W-1:0]     r_shift;
    logic [SYNC_BITS-1:0]  r_sync;
    logic                  r_ready;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_div_clr;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_shift_next;
    logic [SYNC_BITS-1:0]  w_sync_next;

    assign o_ready = r_ready && i_enable;
    assign o_tx    = r_tx;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

    assign w_accept     = (r_state == IDLE) && i_valid && o_ready;
    assign w_shift_next = r_shift << 1;
    assign w_sync_next  = r_sync << 1;

    // Field transitions only happen on a tick, where the divider wraps to 0
    // anyway; holding it clear in IDLE and on abort restarts every frame cleanly.
    assign w_div_clr = (r_state == IDLE) || !i_enable;

    manchester_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_div_clr),
        .o_tick  (w_tick)
    );

    // r_tx is always loaded with the level of the half-bit that starts next,
    // so the line changes on the same edge as the counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_hb_cnt <= '0;
            r_shift  <= '0;
            r_sync   <= '0;
            r_ready  <= 1'b0;
            r_tx     <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (!i_enable) begin
            r_state  <= IDLE;
            r_hb_cnt <= '0;
            r_shift  <= '0;
            r_sync   <= '0;
            r_ready  <= 1'b0;
            r_tx     <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx     <= IDLE_LEVEL;
                    r_hb_cnt <= '0;
                    if (w_accept) begin
                        r_shift <= i_data;
                        r_sync  <= SYNC_PATTERN;
                        r_state <= PREAMBLE;
                        r_tx    <= encode(1'b1, 1'b0);
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                PREAMBLE: if (w_tick) begin
                    if (r_hb_cnt == HB_W'(PRE_HB - 1)) begin
                        r_state  <= SYNC;
                        r_hb_cnt <= '0;
                        r_tx     <= encode(r_sync[SYNC_BITS-1], 1'b0);
                    end else begin
                        r_hb_cnt <= r_hb_cnt + 1'b1;
                        r_tx     <= encode(1'b1, ~r_hb_cnt[0]);
                    end
                end
                SYNC: if (w_tick) begin
                    if (r_hb_cnt[0]) r_sync <= w_sync_next;
                    if (r_hb_cnt == HB_W'(SYNC_HB - 1)) begin
                        r_state  <= DATA;
                        r_hb_cnt <= '0;
                        r_tx     <= encode(r_shift[DATA_W-1], 1'b0);
                    end else begin
                        r_hb_cnt <= r_hb_cnt + 1'b1;
                        r_tx     <= r_hb_cnt[0] ? encode(w_sync_next[SYNC_BITS-1], 1'b0)
                                                : encode(r_sync[SYNC_BITS-1], 1'b1);
                    end
                end
                DATA: if (w_tick) begin
                    if (r_hb_cnt[0]) r_shift <= w_shift_next;
                    if (r_hb_cnt == HB_W'(DATA_HB - 1)) begin
                        r_hb_cnt <= '0;
                        r_tx     <= IDLE_LEVEL;
                        r_done   <= 1'b1;
                        if (GAP_HALFBITS == 0) begin
                            // Skipping GAP makes the done cycle itself an IDLE cycle.
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= GAP;
                        end
                    end else begin
                        r_hb_cnt <= r_hb_cnt + 1'b1;
                        r_tx     <= r_hb_cnt[0] ? encode(w_shift_next[DATA_W-1], 1'b0)
                                                : encode(r_shift[DATA_W-1], 1'b1);
                    end
                end
                GAP: if (w_tick) begin
                    if (r_hb_cnt == HB_W'(GAP_LAST)) begin
                        r_state  <= IDLE;
                        r_hb_cnt <= '0;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_hb_cnt <= r_hb_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Bench for manchester_frame_tx: two instances (CLK_DIV=1/GAP=0 and
// CLK_DIV=3/GAP=4), each with a stimulus process that queues the expected
// payload on acceptance and a monitor that rebuilds the expected line waveform
// from the encoding rules and compares it cycle by cycle.
module tb_manchester_frame_tx;

    localparam int DW = 8;
    localparam int P  = 4;
    localparam int S  = 2;

    logic clk;
    int   checks   = 0;
    int   failures = 0;
    int   n_fin    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input int g, input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL cfg%0d %s got=%0d expected=%0d", g, name, got, exp);
        end
    endtask

    // Expected line level in frame cycle c: preamble ones, sync 2'b10, payload MSB first.
    function automatic logic exp_level(input logic [7:0] d, input int cd, input int c);
        int         h;
        int         b;
        logic       v;
        logic [1:0] sp;
        logic [7:0] sh;
        sp = 2'b10;
        h  = c / cd;
        b  = h / 2;
        if (b < P) begin
            v = 1'b1;
        end else if (b < P + S) begin
            sh = 8'(sp >> (S - 1 - (b - P)));
            v  = sh[0];
        end else begin
            sh = d >> (DW - 1 - (b - P - S));
            v  = sh[0];
        end
        return (h % 2 == 1) ? v : ~v;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int CD = (g == 0) ? 1 : 3;
        localparam int GP = (g == 0) ? 0 : 4;
        localparam int F  = 2 * (P + S + DW) * CD;

        typedef struct {
            logic [7:0] d;
            bit         cut;
            int         acc;
        } ent_t;

        logic       rst_n;
        logic       en;
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic       tx;
        logic       busy;
        logic       dn;
        ent_t       q[$];
        int         cyc;
        int         last_acc;

        manchester_frame_tx #(
            .DATA_W        (DW),
            .PREAMBLE_BITS (P),
            .SYNC_BITS     (S),
            .SYNC_PATTERN  (2'b10),
            .CLK_DIV       (CD),
            .GAP_HALFBITS  (GP),
            .IDLE_LEVEL    (1'b0)
        ) dut (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_enable (en),
            .i_data   (dat),
            .i_valid  (vld),
            .o_ready  (rdy),
            .o_tx     (tx),
            .o_busy   (busy),
            .o_done   (dn)
        );

        always @(posedge clk) cyc <= cyc + 1;

        task automatic send(input logic [7:0] d, input bit cut, input bit hold);
            int   n;
            ent_t e;
            @(posedge clk);
            #1;
            dat = d;
            vld = 1'b1;
            n   = 0;
            @(negedge clk);
            while (!rdy && n < 2000) begin
                n++;
                @(negedge clk);
            end
            if (!rdy) begin
                chk(g, "accept_timeout", rdy, 1);
                vld = 1'b0;
            end else begin
                @(posedge clk);
                e.d = d; e.cut = cut; e.acc = cyc;
                q.push_back(e);
                last_acc = cyc;
                #1;
                if (!hold) vld = 1'b0;
            end
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            @(negedge clk);
            while ((busy || !rdy) && n < 2000) begin
                n++;
                @(negedge clk);
            end
            if (busy || !rdy) chk(g, "idle_timeout", busy, 0);
        endtask

        task automatic wait_frame_cycle(input int c);
            int n;
            n = 0;
            @(negedge clk);
            while (cyc != last_acc + 1 + c && n < 2000) begin
                n++;
                @(negedge clk);
            end
        endtask

        // Monitor: compares each frame against the queued expectation.
        initial begin
            ent_t e;
            int   i, mis, fmis, cnt, gmis;
            logic busy_prev;
            busy_prev = 1'b0;
            forever begin
                @(negedge clk);
                if (busy && !busy_prev) begin
                    chk(g, "frame_expected", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk(g, "start_latency", cyc, e.acc + 1);
                        i = 0; mis = 0; fmis = 0;
                        while (i < F && busy) begin
                            if (tx !== exp_level(e.d, CD, i)) mis++;
                            if (dn !== 1'b0) fmis++;
                            if (rdy !== 1'b0) fmis++;
                            i++;
                            @(negedge clk);
                        end
                        chk(g, "frame_flags", fmis, 0);
                        if (e.cut) begin
                            chk(g, "abort_early", i < F, 1);
                            chk(g, "abort_prefix", mis, 0);
                            chk(g, "abort_tx_idle", tx, 0);
                            chk(g, "abort_no_done", dn, 0);
                        end else begin
                            chk(g, "frame_len", i, F);
                            chk(g, "frame_bits", mis, 0);
                            chk(g, "done_pulse", dn, 1);
                            chk(g, "done_tx_idle", tx, 0);
                            chk(g, "ready_at_done", rdy, GP == 0);
                            cnt = 0; gmis = 0;
                            while (busy && cnt < 200) begin
                                if (tx !== 1'b0) gmis++;
                                if (rdy !== 1'b0) gmis++;
                                if (cnt > 0 && dn !== 1'b0) gmis++;
                                cnt++;
                                @(negedge clk);
                            end
                            chk(g, "gap_len", cnt, GP * CD);
                            chk(g, "gap_idle", gmis, 0);
                            chk(g, "ready_after_gap", rdy, 1);
                        end
                    end
                end else if (dn !== 1'b0) begin
                    chk(g, "stray_done", dn, 0);
                end
                busy_prev = busy;
            end
        end

        // Stimulus
        initial begin
            int a1;
            logic [7:0] d;
            rst_n = 1'b0; en = 1'b0; vld = 1'b0; dat = '0; last_acc = 0;
            repeat (3) @(negedge clk);
            chk(g, "rst_tx", tx, 0);
            chk(g, "rst_ready", rdy, 0);
            chk(g, "rst_busy", busy, 0);
            chk(g, "rst_done", dn, 0);
            rst_n = 1'b1;
            en    = 1'b1;
            #1;
            chk(g, "ready_before_edge", rdy, 0);
            @(negedge clk);
            chk(g, "ready_first_edge", rdy, 1);

            send(8'hA5, 1'b0, 1'b0);
            wait_idle();

            // Back-to-back with i_valid held through the frame and gap.
            send(8'h00, 1'b0, 1'b1);
            a1 = last_acc;
            send(8'hFF, 1'b0, 1'b0);
            chk(g, "b2b_spacing", last_acc - a1, F + GP * CD + 1);
            wait_idle();

            // Valid with other data while the preamble is on air.
            d = 8'($urandom);
            send(d, 1'b0, 1'b0);
            repeat (4) begin
                @(posedge clk);
                #1;
                dat = ~d;
                vld = 1'b1;
            end
            @(posedge clk);
            #1;
            vld = 1'b0;
            wait_idle();

            repeat (6) begin
                send(8'($urandom), 1'b0, 1'b0);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            wait_idle();

            // Abort during data bit 3.
            send(8'($urandom), 1'b1, 1'b0);
            wait_frame_cycle((2 * (P + S) + 6) * CD);
            en = 1'b0;
            @(negedge clk);
            chk(g, "abort_busy", busy, 0);
            repeat (3) begin
                @(negedge clk);
                chk(g, "disabled_ready", rdy, 0);
            end
            en = 1'b1;
            send(8'($urandom), 1'b0, 1'b0);
            wait_idle();

            // Asynchronous reset mid-SYNC.
            send(8'($urandom), 1'b1, 1'b0);
            wait_frame_cycle(2 * P * CD + 1);
            #2;
            rst_n = 1'b0;
            #1;
            chk(g, "async_rst_tx", tx, 0);
            chk(g, "async_rst_busy", busy, 0);
            chk(g, "async_rst_ready", rdy, 0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk(g, "post_rst_ready_low", rdy, 0);
            @(negedge clk);
            chk(g, "post_rst_ready_high", rdy, 1);
            send(8'($urandom), 1'b0, 1'b0);
            wait_idle();

            repeat (3) @(negedge clk);
            chk(g, "queue_empty", q.size(), 0);
            n_fin++;
        end
    end

    initial begin
        int n;
        n = 0;
        while (n_fin < 2 && n < 60000) begin
            n++;
            @(posedge clk);
        end
        chk(-1, "run_complete", n_fin, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
